gray_updown_counter: RTL and testbench
======================================

Name: gray_updown_counter

Overview:
Parametrised up/down Gray-code counter with enable, synchronous load, wrap/saturate mode and terminal-count flags. It is the general-width successor of the fixed 3-bit up/down Gray counter. It holds a binary count internally and drives a registered Gray output, so the Gray bus is glitch-free and safe to sample in another clock domain. Typical uses are FIFO pointers, rotary/position sequencing and low-toggle state counters.

Parameters:
- WIDTH, default 4: counter width in bits; legal range 2..16.
- WRAP, default 1: 1 = wrap around at the ends; 0 = saturate at the ends.
- RESET_VAL, default 0: binary value loaded on reset; must be less than 2^WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; the counter steps one position per cycle while high.
- ud  input  1  direction; 1 = up, 0 = down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value to load.
- qgray  output  WIDTH  registered Gray code of the count.
- qbin  output  WIDTH  registered binary count.
- at_max  output  1  combinational; high when qbin is all ones.
- at_min  output  1  combinational; high when qbin is zero.
- wrap_p  output  1  registered; one-cycle pulse after a wrap event.
- sat  output  1  registered; high while a step was blocked by saturation.

Behaviour:
- Reset (reset=0, asynchronous):
  - qbin = RESET_VAL, qgray = RESET_VAL ^ (RESET_VAL >> 1).
  - wrap_p = 0, sat = 0.
  - Release of reset is synchronous to clk; no counting occurs in the release cycle unless en is high at that edge.
- Priority each rising edge is load > en > hold.
- load=1: qbin <= load_val; qgray <= bin2gray(load_val); wrap_p <= 0; sat <= 0. The en input is ignored that cycle.
- en=1, ud=1:
  - Not at_max: qbin+1.
  - At_max with WRAP=1: qbin <= 0, wrap_p <= 1.
  - At_max with WRAP=0: hold, sat <= 1.
- en=1, ud=0:
  - Not at_min: qbin-1.
  - At_min with WRAP=1: qbin <= all ones, wrap_p <= 1.
  - At_min with WRAP=0: hold, sat <= 1.
- en=0, load=0: hold the count; wrap_p <= 0; sat keeps its value.
- sat clears on any successful step, any load, or reset.
- qgray always equals bin2gray(qbin) on the same cycle; both update on the same edge, so latency from the input edge to the output is 1 cycle.
- Exactly one bit of qgray toggles per step, including across the wrap. There are no Gray transitions on hold or saturation.
- Direction may change on any cycle; the new direction applies to that edge's step.
- Arithmetic is modulo 2^WIDTH; there are no X or default states, since every binary value is legal.
- An assertion flags more than one qgray bit changing on a cycle with en=1 and load=0.

Decomposition:
- Package gray_pkg:
  - Functions bin2gray(b) = b ^ (b >> 1) and gray2bin (prefix XOR from the MSB), both width-generic.
  - Constants for the direction encoding: UP=1, DOWN=0.
- The counter uses gray_pkg::bin2gray for its next-state Gray value.
- No sub-module; gray2bin exists for benches and consumers in other clock domains.

Test Plan:
1. WIDTH=3, WRAP=1, reset then en=1, ud=1 for 9 cycles -> qgray = 000,001,011,010,110,111,101,100,000; wrap_p high exactly the cycle after 100->000.
2. WIDTH=3, en=1, ud=0 from reset -> qgray = 100 (qbin=7) after 1 cycle with wrap_p=1, then 101, 111, 110.
3. WIDTH=3, WRAP=0, load_val=6, then up 3 cycles -> qbin 7, 7, 7; sat=1 from the 2nd cycle; then ud=0 -> qbin=6, sat=0.
4. WIDTH=4, load=1 and en=1 together with load_val=9 -> qbin=9, qgray=1101; no step that cycle.
5. WIDTH=4, counting up at qbin=5, assert reset mid-cycle -> outputs return to 0 immediately without waiting for clk; after release, first en edge gives qbin=1.
6. WIDTH=8, random en/ud/load for 10k cycles -> qgray == bin2gray(qbin) every cycle; one-bit-change assertion never fires.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and direction encoding for the up/down Gray counter
// and for consumers that resynchronise its Gray bus in another clock domain.
package gray_pkg;

  // Widest counter supported; the helpers work on this width and callers
  // zero-extend on the way in and truncate on the way out.
  localparam int MAX_W = 16;

  // Direction encoding on the ud input.
  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR running down from the MSB.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray-code counter. The count is kept in binary; the
// Gray output is registered on the same edge so it is glitch-free and safe
// to sample from another clock domain.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int WRAP      = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] qgray,
  output logic [WIDTH-1:0] qbin,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_p,
  output logic             sat
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
    $error("gray_updown_counter: WIDTH must be in 2..16");
  end
  if (RESET_VAL < 0 || RESET_VAL >= (1 << WIDTH)) begin : g_bad_reset_val
    $error("gray_updown_counter: RESET_VAL must fit in WIDTH bits");
  end

  logic [WIDTH-1:0] nxt_bin;
  logic [WIDTH-1:0] nxt_gray;
  logic             nxt_wrap;
  logic             nxt_sat;

  // Terminal-count flags are decoded straight from the registered count.
  assign at_max = &qbin;
  assign at_min = ~|qbin;

  // Next-state selection: load beats en beats hold; ends wrap or saturate.
  always_comb begin
    nxt_bin  = qbin;
    nxt_wrap = 1'b0;
    nxt_sat  = sat;
    if (load) begin
      nxt_bin = load_val;
      nxt_sat = 1'b0;
    end else if (en) begin
      if (ud == UP) begin
        if (!at_max) begin
          nxt_bin = qbin + WIDTH'(1);
          nxt_sat = 1'b0;
        end else if (WRAP != 0) begin
          nxt_bin  = '0;
          nxt_wrap = 1'b1;
          nxt_sat  = 1'b0;
        end else begin
          nxt_sat = 1'b1;
        end
      end else begin
        if (!at_min) begin
          nxt_bin = qbin - WIDTH'(1);
          nxt_sat = 1'b0;
        end else if (WRAP != 0) begin
          nxt_bin  = '1;
          nxt_wrap = 1'b1;
          nxt_sat  = 1'b0;
        end else begin
          nxt_sat = 1'b1;
        end
      end
    end
    nxt_gray = WIDTH'(bin2gray(MAX_W'(nxt_bin)));
  end

  // Binary count, Gray image and event flags all update on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qbin   <= RST_BIN;
      qgray  <= RST_GRAY;
      wrap_p <= 1'b0;
      sat    <= 1'b0;
    end else begin
      qbin   <= nxt_bin;
      qgray  <= nxt_gray;
      wrap_p <= nxt_wrap;
      sat    <= nxt_sat;
    end
  end

  // A counting cycle may move at most one Gray bit, including across a wrap.
  a_one_bit_step : assert property (
    @(posedge clk) disable iff (!reset)
    (en && !load) |=> ($countones(qgray ^ $past(qgray)) <= 1)
  );

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed-vector bench for gray_updown_counter: a 3-bit wrapping instance
// and a 4-bit saturating instance share clock and reset.
module tb_gray_updown_counter;

  typedef struct {
    bit         dut;   // 0 = 3-bit wrapping, 1 = 4-bit saturating
    logic [3:0] bin;
    logic [3:0] gray;
    bit         wr;
    bit         st;
  } exp_t;

  logic clk;
  logic reset;

  logic       a_en, a_ud, a_load;
  logic [2:0] a_lv, a_qgray, a_qbin;
  logic       a_max, a_min, a_wrap, a_sat;

  logic       b_en, b_ud, b_load;
  logic [3:0] b_lv, b_qgray, b_qbin;
  logic       b_max, b_min, b_wrap, b_sat;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  gray_updown_counter #(.WIDTH(3), .WRAP(1), .RESET_VAL(0)) u_wrap (
    .clk(clk), .reset(reset), .en(a_en), .ud(a_ud), .load(a_load),
    .load_val(a_lv), .qgray(a_qgray), .qbin(a_qbin), .at_max(a_max),
    .at_min(a_min), .wrap_p(a_wrap), .sat(a_sat)
  );

  gray_updown_counter #(.WIDTH(4), .WRAP(0), .RESET_VAL(0)) u_sat (
    .clk(clk), .reset(reset), .en(b_en), .ud(b_ud), .load(b_load),
    .load_val(b_lv), .qgray(b_qgray), .qbin(b_qbin), .at_max(b_max),
    .at_min(b_min), .wrap_p(b_wrap), .sat(b_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, req, $time);
    end
  endtask

  // Compare every output of one instance against an expected entry.
  task automatic compare(input exp_t e, input string tag);
    logic [3:0] bin, gray;
    logic mx, mn, wr, st;
    bit emx, emn;
    if (e.dut) begin
      bin = b_qbin; gray = b_qgray; mx = b_max; mn = b_min; wr = b_wrap; st = b_sat;
      emx = (e.bin == 4'd15);
    end else begin
      bin = {1'b0, a_qbin}; gray = {1'b0, a_qgray};
      mx = a_max; mn = a_min; wr = a_wrap; st = a_sat;
      emx = (e.bin == 4'd7);
    end
    emn = (e.bin == 4'd0);
    chk({tag, ".qbin"},   bin,       e.bin);
    chk({tag, ".qgray"},  gray,      e.gray);
    chk({tag, ".at_max"}, {3'b0, mx}, {3'b0, emx});
    chk({tag, ".at_min"}, {3'b0, mn}, {3'b0, emn});
    chk({tag, ".wrap_p"}, {3'b0, wr}, {3'b0, e.wr});
    chk({tag, ".sat"},    {3'b0, st}, {3'b0, e.st});
  endtask

  // Monitor: the counters present a new result one clock after each vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e, e.dut ? "sat4" : "wrap3");
      end
    end
  end

  function automatic void expect_out(input bit dut, input logic [3:0] bin,
                                     input logic [3:0] gray, input bit wr, input bit st);
    exp_t e;
    e.dut = dut; e.bin = bin; e.gray = gray; e.wr = wr; e.st = st;
    q.push_back(e);
  endfunction

  // Drive one vector into the selected instance (the other one idles).
  task automatic step(input bit dut, input logic en, input logic ud, input logic ld,
                      input logic [3:0] lv, input logic [3:0] bin,
                      input logic [3:0] gray, input bit wr, input bit st);
    @(negedge clk);
    a_en = 1'b0; a_load = 1'b0; b_en = 1'b0; b_load = 1'b0;
    if (dut) begin
      b_en = en; b_ud = ud; b_load = ld; b_lv = lv;
    end else begin
      a_en = en; a_ud = ud; a_load = ld; a_lv = lv[2:0];
    end
    expect_out(dut, bin, gray, wr, st);
  endtask

  initial begin
    exp_t zero_a, zero_b;
    zero_a.dut = 1'b0; zero_a.bin = 4'd0; zero_a.gray = 4'b0000; zero_a.wr = 1'b0; zero_a.st = 1'b0;
    zero_b = zero_a;   zero_b.dut = 1'b1;

    reset = 1'b0;
    a_en = 1'b0; a_ud = 1'b1; a_load = 1'b0; a_lv = '0;
    b_en = 1'b0; b_ud = 1'b1; b_load = 1'b0; b_lv = '0;
    repeat (2) @(posedge clk);
    #2;
    compare(zero_a, "rst_wrap3");
    compare(zero_b, "rst_sat4");

    // Release with en low: nothing moves.
    @(negedge clk);
    reset = 1'b1;
    expect_out(1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);

    // 3-bit wrap counting up through the wrap.
    step(0, 1, 1, 0, 4'd0, 4'd1, 4'b0001, 0, 0);
    step(0, 1, 1, 0, 4'd0, 4'd2, 4'b0011, 0, 0);
    step(0, 1, 1, 0, 4'd0, 4'd3, 4'b0010, 0, 0);
    step(0, 1, 1, 0, 4'd0, 4'd4, 4'b0110, 0, 0);
    step(0, 1, 1, 0, 4'd0, 4'd5, 4'b0111, 0, 0);
    step(0, 1, 1, 0, 4'd0, 4'd6, 4'b0101, 0, 0);
    step(0, 1, 1, 0, 4'd0, 4'd7, 4'b0100, 0, 0);
    step(0, 1, 1, 0, 4'd0, 4'd0, 4'b0000, 1, 0);
    step(0, 1, 1, 0, 4'd0, 4'd1, 4'b0001, 0, 0);
    step(0, 0, 1, 0, 4'd0, 4'd1, 4'b0001, 0, 0);

    // 3-bit counting down across zero, then reversing.
    step(0, 0, 0, 1, 4'd0, 4'd0, 4'b0000, 0, 0);
    step(0, 1, 0, 0, 4'd0, 4'd7, 4'b0100, 1, 0);
    step(0, 1, 0, 0, 4'd0, 4'd6, 4'b0101, 0, 0);
    step(0, 1, 0, 0, 4'd0, 4'd5, 4'b0111, 0, 0);
    step(0, 1, 0, 0, 4'd0, 4'd4, 4'b0110, 0, 0);
    step(0, 1, 1, 0, 4'd0, 4'd5, 4'b0111, 0, 0);

    // 4-bit saturating at the top.
    step(1, 0, 1, 1, 4'd14, 4'd14, 4'b1001, 0, 0);
    step(1, 1, 1, 0, 4'd0,  4'd15, 4'b1000, 0, 0);
    step(1, 1, 1, 0, 4'd0,  4'd15, 4'b1000, 0, 1);
    step(1, 1, 1, 0, 4'd0,  4'd15, 4'b1000, 0, 1);
    step(1, 0, 1, 0, 4'd0,  4'd15, 4'b1000, 0, 1);
    step(1, 1, 0, 0, 4'd0,  4'd14, 4'b1001, 0, 0);

    // 4-bit saturating at the bottom; load clears sat and beats en.
    step(1, 0, 0, 1, 4'd0, 4'd0,  4'b0000, 0, 0);
    step(1, 1, 0, 0, 4'd0, 4'd0,  4'b0000, 0, 1);
    step(1, 0, 0, 0, 4'd0, 4'd0,  4'b0000, 0, 1);
    step(1, 1, 1, 1, 4'd9, 4'd9,  4'b1101, 0, 0);
    step(1, 1, 1, 0, 4'd0, 4'd10, 4'b1111, 0, 0);
    step(1, 1, 0, 0, 4'd0, 4'd9,  4'b1101, 0, 0);
    step(1, 0, 1, 1, 4'd4, 4'd4,  4'b0110, 0, 0);
    step(1, 1, 1, 0, 4'd0, 4'd5,  4'b0111, 0, 0);

    // Asynchronous reset mid-cycle while still counting.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    compare(zero_a, "async_wrap3");
    compare(zero_b, "async_sat4");
    @(posedge clk);
    #1;
    compare(zero_b, "held_sat4");

    // Release with en high: first edge counts.
    @(negedge clk);
    reset = 1'b1;
    expect_out(1'b1, 4'd1, 4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    b_en = 1'b0;

    repeat (20) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
